lfc_mshr_table: RTL and testbench

Parametrised miss-status holding table for the lockup-free cache (LFC). Accepts primary and secondary misses from the cache front end, tags each with a UUID, dispatches one request per RAM bank with a valid/ready handshake, and retires entries on per-bank completion. Generalises the fixed 4-bank LFC miss path to NUM_ENTRIES outstanding misses, address-interleaved banks, optional secondary-miss merging, and halt-driven drain.

---
 rtl/lfc_pkg.sv | 19 +
 rtl/lfc_mshr_pick.sv | 24 ++
 rtl/lfc_mshr_table.sv | 207 ++++++++++++++++++++
 tb/tb_lfc_mshr_table.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfc_pkg.sv
// Shared types and width helpers for the lockup-free cache miss-status holding table.
package lfc_pkg;

  typedef enum logic [1:0] {
    MSHR_FREE    = 2'd0,
    MSHR_PENDING = 2'd1,
    MSHR_ISSUED  = 2'd2
  } mshr_state_t;

  // Index width that stays legal (>=1 bit) even for a single-element set.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int uuid_min_bits(input int num_entries);
    return $clog2(num_entries);
  endfunction

endpackage

// File: rtl/lfc_mshr_pick.sv
// Lowest-index priority encoder with a found flag; used for allocation and per-bank dispatch.
module lfc_mshr_pick
  import lfc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_bits(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfc_mshr_table.sv
// Miss-status holding table: allocates misses, dispatches one request per bank, retires on completion.
// Define LFC_MSHR_MERGE_EN to merge secondary read misses into an existing read entry.
module lfc_mshr_table
  import lfc_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int NUM_ENTRIES = 8,
  parameter int UUID_SIZE   = 4,
  parameter int ADDR_W      = 32,
  parameter int BLOCK_OFF   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  miss_valid,
  output logic                                  miss_ready,
  input  logic [ADDR_W-1:0]                     miss_addr,
  input  logic                                  miss_rw,
  input  logic [31:0]                           miss_store,
  output logic [UUID_SIZE-1:0]                  miss_uuid,
  output logic                                  miss_merged,
  output logic [NUM_BANKS-1:0]                  disp_valid,
  input  logic [NUM_BANKS-1:0]                  disp_ready,
  output logic [NUM_BANKS-1:0][ADDR_W-1:0]      disp_addr,
  output logic [NUM_BANKS-1:0]                  disp_rw,
  output logic [NUM_BANKS-1:0][31:0]            disp_store,
  output logic [NUM_BANKS-1:0][UUID_SIZE-1:0]   disp_uuid,
  input  logic [NUM_BANKS-1:0]                  cmpl_valid,
  input  logic [NUM_BANKS-1:0][UUID_SIZE-1:0]   cmpl_uuid,
  output logic [NUM_ENTRIES-1:0]                entry_busy,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]      occupancy,
  input  logic                                  halt,
  output logic                                  flushed,
  output logic                                  cmpl_err
);

  localparam int EW = idx_bits(NUM_ENTRIES);
  localparam int BW = idx_bits(NUM_BANKS);
  localparam int OW = $clog2(NUM_ENTRIES + 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << BLOCK_OFF) - ADDR_W'(1));

  typedef struct packed {
    mshr_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic            rw;
    logic [31:0]     store;
    logic [BW-1:0]   bank;
  } mshr_entry_t;

  mshr_entry_t entry_q [NUM_ENTRIES];
  mshr_entry_t entry_d [NUM_ENTRIES];

  logic [NUM_BANKS-1:0]          lock_q, lock_d;
  logic [NUM_BANKS-1:0][EW-1:0]  lock_idx_q, lock_idx_d;
  logic [NUM_BANKS-1:0][EW-1:0]  sel_idx;
  logic [OW-1:0]                 occupancy_q, occupancy_d;
  logic                          flushed_q, flushed_d;
  logic                          cmpl_err_q, cmpl_err_d;

  logic [ADDR_W-1:0]      miss_blk;
  logic [BW-1:0]          miss_bank;
  logic [NUM_ENTRIES-1:0] busy_vec, free_vec;
  logic                   hazard, merge_hit;
  logic [EW-1:0]          merge_idx, alloc_idx;
  logic                   alloc_found, accept, alloc_en;

  assign miss_blk = miss_addr & BLK_MASK;

  generate
    if (NUM_BANKS > 1) begin : g_bank_sel
      assign miss_bank = miss_addr[BLOCK_OFF +: BW];
    end else begin : g_bank_one
      assign miss_bank = '0;
    end
  endgenerate

  // Block-address lookup against live entries: write ordering hazards and read merge hits.
  always_comb begin
    busy_vec  = '0;
    free_vec  = '0;
    hazard    = 1'b0;
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy_vec[i] = (entry_q[i].state != MSHR_FREE);
      free_vec[i] = !busy_vec[i];
      if (busy_vec[i] && entry_q[i].addr == miss_blk) begin
        if (entry_q[i].rw || miss_rw) begin
          hazard = 1'b1;
        end
`ifdef LFC_MSHR_MERGE_EN
        else if (!merge_hit) begin
          merge_hit = 1'b1;
          merge_idx = EW'(i);
        end
`endif
      end
    end
  end

  lfc_mshr_pick #(.N(NUM_ENTRIES), .W(EW)) u_alloc_pick (
    .req   (free_vec),
    .idx   (alloc_idx),
    .found (alloc_found)
  );

  assign miss_ready  = !rst && !halt && !hazard && (alloc_found || merge_hit);
  assign accept      = miss_valid && miss_ready;
  assign alloc_en    = accept && !merge_hit;
  assign miss_uuid   = UUID_SIZE'(merge_hit ? merge_idx : alloc_idx);
  assign miss_merged = accept && merge_hit;

  // A presented request is locked so a lower-index newcomer cannot displace it before it is taken.
  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_disp
    logic [NUM_ENTRIES-1:0] pend_vec;
    logic [EW-1:0]          pick_idx;
    logic                   pick_found;

    always_comb begin
      pend_vec = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        pend_vec[i] = (entry_q[i].state == MSHR_PENDING) && (entry_q[i].bank == BW'(gb));
      end
    end

    lfc_mshr_pick #(.N(NUM_ENTRIES), .W(EW)) u_disp_pick (
      .req   (pend_vec),
      .idx   (pick_idx),
      .found (pick_found)
    );

    assign sel_idx[gb]    = lock_q[gb] ? lock_idx_q[gb] : pick_idx;
    assign disp_valid[gb] = lock_q[gb] || pick_found;
    assign disp_addr[gb]  = entry_q[sel_idx[gb]].addr;
    assign disp_rw[gb]    = entry_q[sel_idx[gb]].rw;
    assign disp_store[gb] = entry_q[sel_idx[gb]].store;
    assign disp_uuid[gb]  = UUID_SIZE'(sel_idx[gb]);
    assign lock_d[gb]     = disp_valid[gb] && !disp_ready[gb];
    assign lock_idx_d[gb] = sel_idx[gb];
  end

  always_comb begin
    cmpl_err_d  = cmpl_err_q;
    occupancy_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (alloc_en) begin
      entry_d[alloc_idx].state = MSHR_PENDING;
      entry_d[alloc_idx].addr  = miss_blk;
      entry_d[alloc_idx].rw    = miss_rw;
      entry_d[alloc_idx].store = miss_store;
      entry_d[alloc_idx].bank  = miss_bank;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (disp_valid[b] && disp_ready[b]) begin
        entry_d[sel_idx[b]].state = MSHR_ISSUED;
      end
    end
    // Only an ISSUED entry owned by the reporting bank may retire; anything else is flagged.
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (cmpl_valid[b]) begin
        if ((32'(cmpl_uuid[b]) < 32'(NUM_ENTRIES)) &&
            (entry_q[cmpl_uuid[b][EW-1:0]].state == MSHR_ISSUED) &&
            (entry_q[cmpl_uuid[b][EW-1:0]].bank == BW'(b))) begin
          entry_d[cmpl_uuid[b][EW-1:0]].state = MSHR_FREE;
        end else begin
          cmpl_err_d = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entry_d[i].state != MSHR_FREE) begin
        occupancy_d = occupancy_d + OW'(1);
      end
    end
  end

  assign flushed_d = halt && (occupancy_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
      lock_q      <= '0;
      lock_idx_q  <= '0;
      occupancy_q <= '0;
      flushed_q   <= 1'b0;
      cmpl_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_q[i] <= entry_d[i];
      end
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      occupancy_q <= occupancy_d;
      flushed_q   <= flushed_d;
      cmpl_err_q  <= cmpl_err_d;
    end
  end

  assign entry_busy = busy_vec;
  assign occupancy  = occupancy_q;
  assign flushed    = flushed_q;
  assign cmpl_err   = cmpl_err_q;

endmodule

// File: tb/tb_lfc_mshr_table.sv
// Directed testbench for lfc_mshr_table with default parameters (4 banks, 8 entries).
module tb_lfc_mshr_table;

  logic              clk;
  logic              rst;
  logic              miss_valid;
  logic              miss_ready;
  logic [31:0]       miss_addr;
  logic              miss_rw;
  logic [31:0]       miss_store;
  logic [3:0]        miss_uuid;
  logic              miss_merged;
  logic [3:0]        disp_valid;
  logic [3:0]        disp_ready;
  logic [3:0][31:0]  disp_addr;
  logic [3:0]        disp_rw;
  logic [3:0][31:0]  disp_store;
  logic [3:0][3:0]   disp_uuid;
  logic [3:0]        cmpl_valid;
  logic [3:0][3:0]   cmpl_uuid;
  logic [7:0]        entry_busy;
  logic [3:0]        occupancy;
  logic              halt;
  logic              flushed;
  logic              cmpl_err;

  int errors = 0;
  int checks = 0;

  lfc_mshr_table dut (
    .clk         (clk),
    .rst         (rst),
    .miss_valid  (miss_valid),
    .miss_ready  (miss_ready),
    .miss_addr   (miss_addr),
    .miss_rw     (miss_rw),
    .miss_store  (miss_store),
    .miss_uuid   (miss_uuid),
    .miss_merged (miss_merged),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_addr   (disp_addr),
    .disp_rw     (disp_rw),
    .disp_store  (disp_store),
    .disp_uuid   (disp_uuid),
    .cmpl_valid  (cmpl_valid),
    .cmpl_uuid   (cmpl_uuid),
    .entry_busy  (entry_busy),
    .occupancy   (occupancy),
    .halt        (halt),
    .flushed     (flushed),
    .cmpl_err    (cmpl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    miss_valid = 1'b0;
    miss_addr  = '0;
    miss_rw    = 1'b0;
    miss_store = '0;
    disp_ready = '0;
    cmpl_valid = '0;
    cmpl_uuid  = '0;
    halt       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    miss_valid = 1'b1;
    miss_addr  = 32'h100;
    tick();
    #1;
    checks++;
    if (miss_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_in_rst: got %0b expected 0", miss_ready); end
    miss_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (occupancy !== 4'd0) begin errors++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++;
    if (disp_valid !== 4'h0) begin errors++; $display("[TB] FAIL reset_disp_valid: got %h expected 0", disp_valid); end
    checks++;
    if (entry_busy !== 8'h00) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 00", entry_busy); end
    checks++;
    if (flushed !== 1'b0 || cmpl_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got flushed=%0b err=%0b expected 0 0", flushed, cmpl_err); end
    checks++;
    if (miss_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_after: got %0b expected 1", miss_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    miss_valid = 1'b1;
    miss_addr  = 32'h100;
    miss_rw    = 1'b0;
    #1;
    checks++;
    if (miss_ready !== 1'b1 || miss_uuid !== 4'd0 || miss_merged !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_accept: got ready=%0b uuid=%0d merged=%0b expected 1 0 0", miss_ready, miss_uuid, miss_merged);
    end
    tick();
    miss_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 4'd1) begin errors++; $display("[TB] FAIL basic_occ1: got %0d expected 1", occupancy); end
    checks++;
    if (disp_valid !== 4'b0001 || disp_addr[0] !== 32'h100 || disp_uuid[0] !== 4'd0) begin
      errors++; $display("[TB] FAIL basic_disp: got valid=%h addr=%h uuid=%0d expected 1 00000100 0", disp_valid, disp_addr[0], disp_uuid[0]);
    end
    disp_ready = 4'b0001;
    tick();
    disp_ready = 4'b0000;
    #1;
    checks++;
    if (disp_valid !== 4'h0) begin errors++; $display("[TB] FAIL basic_disp_taken: got %h expected 0", disp_valid); end
    cmpl_valid   = 4'b0001;
    cmpl_uuid[0] = 4'd0;
    tick();
    cmpl_valid = 4'b0000;
    #1;
    checks++;
    if (occupancy !== 4'd0 || cmpl_err !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_retire: got occ=%0d err=%0b expected 0 0", occupancy, cmpl_err);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      miss_valid = 1'b1;
      miss_addr  = 32'h1000 + 32'(i * 16);
      miss_rw    = 1'b0;
      #1;
      checks++;
      if (miss_uuid !== 4'(i) || miss_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL fill_uuid_%0d: got uuid=%0d ready=%0b expected %0d 1", i, miss_uuid, miss_ready, i);
      end
      tick();
    end
    miss_addr = 32'h2000;
    #1;
    checks++;
    if (occupancy !== 4'd8 || miss_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_full: got occ=%0d ready=%0b expected 8 0", occupancy, miss_ready);
    end
    disp_ready = 4'hF;
    tick();
    disp_ready = 4'h0;
    #1;
    checks++;
    if (disp_valid !== 4'hF || disp_uuid[0] !== 4'd4 || disp_uuid[3] !== 4'd7) begin
      errors++; $display("[TB] FAIL fill_next_disp: got valid=%h uuid0=%0d uuid3=%0d expected F 4 7", disp_valid, disp_uuid[0], disp_uuid[3]);
    end
    cmpl_valid   = 4'b0100;
    cmpl_uuid[2] = 4'd2;
    #1;
    checks++;
    if (miss_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_same_cycle_realloc: got %0b expected 0", miss_ready); end
    tick();
    cmpl_valid = 4'b0000;
    #1;
    checks++;
    if (miss_ready !== 1'b1 || miss_uuid !== 4'd2) begin
      errors++; $display("[TB] FAIL fill_realloc: got ready=%0b uuid=%0d expected 1 2", miss_ready, miss_uuid);
    end
    tick();
    miss_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 4'd8 || entry_busy !== 8'hFF) begin
      errors++; $display("[TB] FAIL fill_refull: got occ=%0d busy=%h expected 8 FF", occupancy, entry_busy);
    end
  endtask

  task automatic test_merge();
    logic [3:0] exp_uuid;
    logic       exp_merged;
    logic [3:0] exp_occ;
`ifdef LFC_MSHR_MERGE_EN
    exp_uuid = 4'd0; exp_merged = 1'b1; exp_occ = 4'd1;
`else
    exp_uuid = 4'd1; exp_merged = 1'b0; exp_occ = 4'd2;
`endif
    do_reset();
    miss_valid = 1'b1;
    miss_addr  = 32'h200;
    miss_rw    = 1'b0;
    tick();
    miss_addr = 32'h208;
    #1;
    checks++;
    if (miss_ready !== 1'b1 || miss_uuid !== exp_uuid || miss_merged !== exp_merged) begin
      errors++; $display("[TB] FAIL merge_second: got ready=%0b uuid=%0d merged=%0b expected 1 %0d %0b", miss_ready, miss_uuid, miss_merged, exp_uuid, exp_merged);
    end
    tick();
    miss_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== exp_occ || miss_merged !== 1'b0) begin
      errors++; $display("[TB] FAIL merge_occ: got occ=%0d merged=%0b expected %0d 0", occupancy, miss_merged, exp_occ);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    miss_valid = 1'b1;
    miss_addr  = 32'h300;
    miss_rw    = 1'b1;
    miss_store = 32'hCAFE_F00D;
    tick();
    miss_addr = 32'h304;
    miss_rw   = 1'b0;
    #1;
    checks++;
    if (miss_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_stall: got %0b expected 0", miss_ready); end
    checks++;
    if (disp_valid[0] !== 1'b1 || disp_rw[0] !== 1'b1 || disp_store[0] !== 32'hCAFE_F00D) begin
      errors++; $display("[TB] FAIL hazard_write_disp: got valid=%0b rw=%0b store=%h expected 1 1 cafef00d", disp_valid[0], disp_rw[0], disp_store[0]);
    end
    disp_ready = 4'b0001;
    tick();
    disp_ready = 4'b0000;
    cmpl_valid   = 4'b0001;
    cmpl_uuid[0] = 4'd0;
    #1;
    checks++;
    if (miss_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_stall_cmpl_cycle: got %0b expected 0", miss_ready); end
    tick();
    cmpl_valid = 4'b0000;
    #1;
    checks++;
    if (miss_ready !== 1'b1 || miss_uuid !== 4'd0) begin
      errors++; $display("[TB] FAIL hazard_release: got ready=%0b uuid=%0d expected 1 0", miss_ready, miss_uuid);
    end
    tick();
    miss_valid = 1'b0;
    #1;
    checks++;
    if (disp_valid !== 4'b0001 || disp_addr[0] !== 32'h300 || disp_rw[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL hazard_aligned_addr: got valid=%h addr=%h rw=%0b expected 1 00000300 0", disp_valid, disp_addr[0], disp_rw[0]);
    end
  endtask

  task automatic test_multi_cmpl();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      miss_valid = 1'b1;
      miss_addr  = 32'h400 + 32'(i * 16);
      miss_rw    = 1'b0;
      tick();
    end
    miss_valid = 1'b0;
    disp_ready = 4'hF;
    #1;
    checks++;
    if (disp_valid !== 4'hF || disp_uuid[2] !== 4'd2) begin
      errors++; $display("[TB] FAIL multi_disp: got valid=%h uuid2=%0d expected F 2", disp_valid, disp_uuid[2]);
    end
    tick();
    disp_ready = 4'h0;
    cmpl_valid = 4'hF;
    cmpl_uuid  = {4'd3, 4'd2, 4'd1, 4'd0};
    tick();
    cmpl_valid = 4'h0;
    #1;
    checks++;
    if (occupancy !== 4'd0 || entry_busy !== 8'h00 || cmpl_err !== 1'b0) begin
      errors++; $display("[TB] FAIL multi_cmpl: got occ=%0d busy=%h err=%0b expected 0 00 0", occupancy, entry_busy, cmpl_err);
    end
    cmpl_valid   = 4'b0010;
    cmpl_uuid[1] = 4'd5;
    tick();
    cmpl_valid = 4'h0;
    #1;
    checks++;
    if (cmpl_err !== 1'b1) begin errors++; $display("[TB] FAIL cmpl_err_set: got %0b expected 1", cmpl_err); end
    tick();
    checks++;
    if (cmpl_err !== 1'b1) begin errors++; $display("[TB] FAIL cmpl_err_sticky: got %0b expected 1", cmpl_err); end
  endtask

  task automatic test_halt();
    do_reset();
    miss_valid = 1'b1;
    miss_rw    = 1'b0;
    miss_addr  = 32'h500;
    tick();
    miss_addr = 32'h510;
    tick();
    miss_valid = 1'b0;
    disp_ready = 4'b0011;
    tick();
    disp_ready = 4'b0000;
    halt       = 1'b1;
    miss_valid = 1'b1;
    miss_addr  = 32'h600;
    #1;
    checks++;
    if (miss_ready !== 1'b0 || flushed !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_ready: got ready=%0b flushed=%0b expected 0 0", miss_ready, flushed);
    end
    cmpl_valid   = 4'b0001;
    cmpl_uuid[0] = 4'd0;
    tick();
    cmpl_valid   = 4'b0010;
    cmpl_uuid[1] = 4'd1;
    tick();
    cmpl_valid = 4'b0000;
    #1;
    checks++;
    if (occupancy !== 4'd0 || flushed !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_drain: got occ=%0d flushed=%0b expected 0 0", occupancy, flushed);
    end
    tick();
    checks++;
    if (flushed !== 1'b1) begin errors++; $display("[TB] FAIL halt_flushed: got %0b expected 1", flushed); end
    miss_valid = 1'b0;
    halt       = 1'b0;
    #1;
    checks++;
    if (miss_ready !== 1'b1) begin errors++; $display("[TB] FAIL halt_release_ready: got %0b expected 1", miss_ready); end
    tick();
    checks++;
    if (flushed !== 1'b0) begin errors++; $display("[TB] FAIL halt_flushed_fall: got %0b expected 0", flushed); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    miss_valid = 1'b1;
    miss_rw    = 1'b0;
    miss_addr  = 32'h700;
    tick();
    miss_addr = 32'h710;
    tick();
    miss_valid = 1'b0;
    disp_ready = 4'b0001;
    tick();
    disp_ready = 4'b0000;
    #1;
    checks++;
    if (disp_valid !== 4'b0010 || disp_uuid[1] !== 4'd1) begin
      errors++; $display("[TB] FAIL rst_mid_pre: got valid=%h uuid1=%0d expected 2 1", disp_valid, disp_uuid[1]);
    end
    rst          = 1'b1;
    cmpl_valid   = 4'b0001;
    cmpl_uuid[0] = 4'd0;
    miss_valid   = 1'b1;
    miss_addr    = 32'h800;
    #1;
    checks++;
    if (miss_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ready: got %0b expected 0", miss_ready); end
    tick();
    rst        = 1'b0;
    cmpl_valid = 4'b0000;
    miss_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 4'd0 || disp_valid !== 4'h0 || entry_busy !== 8'h00 || cmpl_err !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_clear: got occ=%0d valid=%h busy=%h err=%0b expected 0 0 00 0", occupancy, disp_valid, entry_busy, cmpl_err);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    $display("[TB] starting lfc_mshr_table directed tests");
    test_reset();
    test_basic();
    test_fill();
    test_merge();
    test_hazard();
    test_multi_cmpl();
    test_halt();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
